vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Pixel-timing core for the text-mode GPU. Divides the single system clock into a
//  pixel-clock enable and generates 640x480@60 VGA sync, active-video and frame-tick
//  signals plus the raw pixel/line counters.
//  Downstream text-RAM/font-ROM pipelines delay these outputs themselves.
// PARAMETERS
//  CLK_DIV   2    clk cycles per pixel (1..16). 1 = pix_en stuck high.
//  H_ACTIVE  640  visible pixels/line
//  H_FP      16   horizontal front porch
//  H_SYNC    96   horizontal sync width
//  H_BP      48   horizontal back porch (H_TOTAL = 800)
//  V_ACTIVE  480  visible lines
//  V_FP      10   vertical front porch
//  V_SYNC    2    vertical sync width
//  V_BP      33   vertical back porch (V_TOTAL = 525)
//  HS_POL    0    h_sync asserted level (0 = active-low)
//  VS_POL    0    v_sync asserted level
// PORTS
//  clk      in   1   system clock; all state on rising edge
//  rst_n    in   1   asynchronous active-low reset
//  pix_en   out  1   pixel-clock enable, one clk wide every CLK_DIV clks
//  x        out  10  pixel counter 0..H_TOTAL-1 (counts through blanking)
//  y        out  10  line counter 0..V_TOTAL-1
//  h_sync   out  1   horizontal sync, polarity HS_POL
//  v_sync   out  1   vertical sync, polarity VS_POL
//  active   out  1   1 when x<H_ACTIVE and y<V_ACTIVE
//  animate  out  1   frame tick: 1 while (x==0, y==V_ACTIVE)
// BEHAVIOUR
//  Reset (async, rst_n=0), all outputs registered:
//   - Divider count = 0, pix_en = 0.
//   - x = H_TOTAL-1, y = V_TOTAL-1.
//   - h_sync = v_sync = deasserted (!HS_POL / !VS_POL); active = 0; animate = 0.
//  Divider:
//   - Counts 0..CLK_DIV-1.
//   - pix_en = 1 in the clk cycle where the count == CLK_DIV-1.
//   - First pix_en pulse: CLK_DIV clks after reset release.
//  Counter advance (only on the clk edge where pix_en = 1):
//   - x wraps H_TOTAL-1 -> 0; on that wrap y increments.
//   - y wraps V_TOTAL-1 -> 0 on the same edge that x wraps.
//  Decode:
//   - h_sync, v_sync, active and animate are registered on the same edge as x/y.
//   - They are decoded from the NEXT x/y values, so they are always aligned with x/y.
//   - All outputs hold their value between pix_en edges.
//  Windows (defaults):
//   - h_sync asserted for x in [656,751].
//   - v_sync asserted for y in [490,491].
//   - active for x<640 and y<480.
//   - animate for (x=0, y=480): one pixel period = CLK_DIV clks, once per frame.
//  First pix_en after reset moves to (0,0) with active=1 and both syncs deasserted.
//  Period timing:
//   - Line = 800 pixel periods; frame = 420000 pixel periods.
//   - No drift, no skipped or repeated counts.
//  Reset asserted mid-frame returns immediately to the reset state, without waiting for a clk edge.
//  Counter compares use full 10-bit width; no out-of-range values are ever produced.
// TESTING
//  1. Hold rst_n=0, toggle clk:
//     -> x=799, y=524, active=0, animate=0, h_sync=v_sync=1, pix_en=0.
//  2. CLK_DIV=2, release reset:
//     -> pix_en toggles 0,1 every clk;
//     -> first pix_en edge gives x=0, y=0, active=1.
//  3. Run one line:
//     -> active falls when x goes 639->640;
//     -> h_sync low exactly for x=656..751 (96 pixels);
//     -> at x=799->0, y increments.
//  4. Run a full frame:
//     -> v_sync low only for y=490,491;
//     -> animate high only at (0,480), for 2 clks;
//     -> (524,799) wraps to (0,0).
//  5. Pulse rst_n low for a fraction of a clk mid-line (e.g. x=300, y=100):
//     -> immediate return to reset values;
//     -> restart identical to test 2.
//  6. CLK_DIV=1:
//     -> pix_en constantly 1 after reset;
//     -> frame period = 420000 clks between animate pulses.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel timing bundle (enable, counters, sync/active/frame tick).
interface vga_timing_gen_if;
    logic       pix_en;
    logic [9:0] x;
    logic [9:0] y;
    logic       h_sync;
    logic       v_sync;
    logic       active;
    logic       animate;
    modport master (output pix_en, x, y, h_sync, v_sync, active, animate);
    modport slave (input pix_en, x, y, h_sync, v_sync, active, animate);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-clock enable divider plus registered VGA sync/active/frame-tick decode.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    vga_timing_gen_if.master  vga_o
);
    localparam logic [3:0] DIV_M1 = 4'(CLK_DIV - 1);
    localparam logic [9:0] HT_M1  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VT_M1  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HA     = 10'(H_ACTIVE);
    localparam logic [9:0] VA     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_S   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_E   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_S   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_E   = 10'(V_ACTIVE + V_FP + V_SYNC);
    logic [3:0] div_q, div_d;
    logic       pix_en_q;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       hs_q, vs_q, act_q, anim_q;
    always_comb begin
        div_d = (div_q == DIV_M1) ? 4'd0 : div_q + 4'd1;
        x_d   = (x_q == HT_M1) ? 10'd0 : x_q + 10'd1;
        y_d   = (x_q != HT_M1) ? y_q : (y_q == VT_M1) ? 10'd0 : y_q + 10'd1;
    end
    // Decode uses the next x/y so the registered flags line up with the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= 4'd0;
            pix_en_q <= 1'b0;
            x_q      <= HT_M1;
            y_q      <= VT_M1;
            hs_q     <= !HS_POL;
            vs_q     <= !VS_POL;
            act_q    <= 1'b0;
            anim_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= (div_d == DIV_M1);
            if (pix_en_q) begin
                x_q    <= x_d;
                y_q    <= y_d;
                hs_q   <= (x_d >= HS_S && x_d < HS_E) ? HS_POL : !HS_POL;
                vs_q   <= (y_d >= VS_S && y_d < VS_E) ? VS_POL : !VS_POL;
                act_q  <= (x_d < HA) && (y_d < VA);
                anim_q <= (x_d == 10'd0) && (y_d == VA);
            end
        end
    end
    assign vga_o.pix_en  = pix_en_q;
    assign vga_o.x       = x_q;
    assign vga_o.y       = y_q;
    assign vga_o.h_sync  = hs_q;
    assign vga_o.v_sync  = vs_q;
    assign vga_o.active  = act_q;
    assign vga_o.animate = anim_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of reset, restart, line/frame windows, mid-line reset and CLK_DIV=1.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int nvec = 0;
    int nerr = 0;
    always #5 clk = ~clk;
    vga_timing_gen_if a_if ();
    vga_timing_gen_if b_if ();
    vga_timing_gen_if c_if ();
    vga_timing_gen dut_a (.clk(clk), .rst_n(rst_n), .vga_o(a_if));
    vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3))
        dut_b (.clk(clk), .rst_n(rst_n), .vga_o(b_if));
    vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3))
        dut_c (.clk(clk), .rst_n(rst_n), .vga_o(c_if));

    // {pix_en, x, y, active, animate, h_sync, v_sync}
    task test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if ({a_if.pix_en, a_if.x, a_if.y, a_if.active, a_if.animate, a_if.h_sync, a_if.v_sync} !== {1'b0, 10'd799, 10'd524, 4'b0011}) begin
            nerr++;
            $display("FAIL reset_a: got pe=%b x=%0d y=%0d act=%b anim=%b hs=%b vs=%b, want pe=0 x=799 y=524 act=0 anim=0 hs=1 vs=1",
                     a_if.pix_en, a_if.x, a_if.y, a_if.active, a_if.animate, a_if.h_sync, a_if.v_sync);
        end
        nvec++;
        if ({b_if.pix_en, b_if.x, b_if.y, b_if.active, b_if.animate, b_if.h_sync, b_if.v_sync} !== {1'b0, 10'd14, 10'd12, 4'b0011}) begin
            nerr++;
            $display("FAIL reset_b: got pe=%b x=%0d y=%0d act=%b anim=%b hs=%b vs=%b, want pe=0 x=14 y=12 act=0 anim=0 hs=1 vs=1",
                     b_if.pix_en, b_if.x, b_if.y, b_if.active, b_if.animate, b_if.h_sync, b_if.v_sync);
        end
    endtask

    // Expects rst_n to have just been released ahead of the next rising edge.
    task test_release(input string tag);
        @(negedge clk);
        nvec++;
        if ({a_if.pix_en, a_if.x, a_if.y} !== {1'b1, 10'd799, 10'd524}) begin
            nerr++;
            $display("FAIL %s_first_pe: got pe=%b x=%0d y=%0d, want pe=1 x=799 y=524", tag, a_if.pix_en, a_if.x, a_if.y);
        end
        @(negedge clk);
        nvec++;
        if ({a_if.pix_en, a_if.x, a_if.y, a_if.active, a_if.h_sync, a_if.v_sync, a_if.animate} !== {1'b0, 10'd0, 10'd0, 4'b1110}) begin
            nerr++;
            $display("FAIL %s_origin: got pe=%b x=%0d y=%0d act=%b hs=%b vs=%b anim=%b, want pe=0 x=0 y=0 act=1 hs=1 vs=1 anim=0",
                     tag, a_if.pix_en, a_if.x, a_if.y, a_if.active, a_if.h_sync, a_if.v_sync, a_if.animate);
        end
        @(negedge clk);
        nvec++;
        if ({a_if.pix_en, a_if.x} !== {1'b1, 10'd0}) begin
            nerr++;
            $display("FAIL %s_hold: got pe=%b x=%0d, want pe=1 x=0", tag, a_if.pix_en, a_if.x);
        end
        @(negedge clk);
        nvec++;
        if ({a_if.pix_en, a_if.x, a_if.y} !== {1'b0, 10'd1, 10'd0}) begin
            nerr++;
            $display("FAIL %s_step: got pe=%b x=%0d y=%0d, want pe=0 x=1 y=0", tag, a_if.pix_en, a_if.x, a_if.y);
        end
    endtask

    // Walks from x=1 through the end of line 0 and onto x=1 of line 1.
    task test_line;
        int hs_low;
        hs_low = 0;
        for (int ex = 2; ex <= 801; ex++) begin
            int xx, yy;
            logic eact, ehs;
            xx   = ex % 800;
            yy   = (ex >= 800) ? 1 : 0;
            eact = (xx < 640);
            ehs  = !(xx >= 656 && xx <= 751);
            repeat (2) @(negedge clk);
            if (!a_if.h_sync) hs_low++;
            nvec++;
            if ({a_if.x, a_if.y, a_if.active, a_if.h_sync, a_if.animate} !== {10'(xx), 10'(yy), eact, ehs, 1'b0}) begin
                nerr++;
                $display("FAIL line_px: got x=%0d y=%0d act=%b hs=%b anim=%b, want x=%0d y=%0d act=%b hs=%b anim=0",
                         a_if.x, a_if.y, a_if.active, a_if.h_sync, a_if.animate, xx, yy, eact, ehs);
            end
        end
        nvec++;
        if (hs_low !== 96) begin
            nerr++;
            $display("FAIL line_hs_width: got %0d pixels, want 96", hs_low);
        end
    endtask

    task test_midreset;
        int i;
        i = 0;
        while (!(a_if.x == 10'd300 && a_if.pix_en == 1'b0) && i < 4000) begin
            @(negedge clk);
            i++;
        end
        nvec++;
        if (i >= 4000) begin
            nerr++;
            $display("FAIL midreset_reach: got x=%0d after %0d clks, want x=300", a_if.x, i);
        end
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if ({a_if.pix_en, a_if.x, a_if.y, a_if.active, a_if.animate, a_if.h_sync, a_if.v_sync} !== {1'b0, 10'd799, 10'd524, 4'b0011}) begin
            nerr++;
            $display("FAIL midreset_async: got pe=%b x=%0d y=%0d act=%b anim=%b hs=%b vs=%b, want pe=0 x=799 y=524 act=0 anim=0 hs=1 vs=1",
                     a_if.pix_en, a_if.x, a_if.y, a_if.active, a_if.animate, a_if.h_sync, a_if.v_sync);
        end
        #1 rst_n = 1'b1;
        test_release("midreset");
    endtask

    // Small geometry: H_TOTAL=15 (hs x=10..12), V_TOTAL=13 (vs y=8..9), animate at (0,6).
    task test_frame;
        int ex, ey, anim_clks, vs_low;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        nvec++;
        if ({b_if.x, b_if.y, b_if.active} !== {10'd0, 10'd0, 1'b1}) begin
            nerr++;
            $display("FAIL frame_origin: got x=%0d y=%0d act=%b, want x=0 y=0 act=1", b_if.x, b_if.y, b_if.active);
        end
        ex = 0;
        ey = 0;
        anim_clks = 0;
        vs_low = 0;
        @(negedge clk);
        if (b_if.animate) anim_clks++;
        for (int p = 1; p <= 195; p++) begin
            logic evs, eanim, eact, ehs;
            ex++;
            if (ex == 15) begin
                ex = 0;
                ey = (ey == 12) ? 0 : ey + 1;
            end
            evs   = !(ey == 8 || ey == 9);
            ehs   = !(ex >= 10 && ex <= 12);
            eanim = (ex == 0 && ey == 6);
            eact  = (ex < 8 && ey < 6);
            @(negedge clk);
            if (b_if.animate) anim_clks++;
            if (!b_if.v_sync) vs_low++;
            nvec++;
            if ({b_if.x, b_if.y, b_if.v_sync, b_if.h_sync, b_if.animate, b_if.active} !== {10'(ex), 10'(ey), evs, ehs, eanim, eact}) begin
                nerr++;
                $display("FAIL frame_px: got x=%0d y=%0d vs=%b hs=%b anim=%b act=%b, want x=%0d y=%0d vs=%b hs=%b anim=%b act=%b",
                         b_if.x, b_if.y, b_if.v_sync, b_if.h_sync, b_if.animate, b_if.active, ex, ey, evs, ehs, eanim, eact);
            end
            @(negedge clk);
            if (b_if.animate) anim_clks++;
        end
        nvec++;
        if (anim_clks !== 2) begin
            nerr++;
            $display("FAIL frame_anim_width: got %0d clks, want 2", anim_clks);
        end
        nvec++;
        if (vs_low !== 30) begin
            nerr++;
            $display("FAIL frame_vs_width: got %0d pixels, want 30", vs_low);
        end
    endtask

    task test_div1;
        int t, per, hi, pe_low;
        logic prev;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nvec++;
        if (c_if.pix_en !== 1'b1) begin
            nerr++;
            $display("FAIL div1_pe_first: got %b, want 1", c_if.pix_en);
        end
        pe_low = 0;
        t = 0;
        while (!c_if.animate && t < 1000) begin
            @(negedge clk);
            if (!c_if.pix_en) pe_low++;
            t++;
        end
        nvec++;
        if (t >= 1000) begin
            nerr++;
            $display("FAIL div1_anim_seen: got none in %0d clks, want a pulse", t);
        end
        per = 0;
        hi = 0;
        prev = 1'b1;
        while (!(c_if.animate && !prev) && per < 1000) begin
            prev = c_if.animate;
            @(negedge clk);
            if (!c_if.pix_en) pe_low++;
            if (c_if.animate) hi++;
            per++;
        end
        nvec++;
        if (per !== 195) begin
            nerr++;
            $display("FAIL div1_frame_period: got %0d clks, want 195", per);
        end
        nvec++;
        if (hi !== 1) begin
            nerr++;
            $display("FAIL div1_anim_width: got %0d clks high, want 1", hi);
        end
        nvec++;
        if (pe_low !== 0) begin
            nerr++;
            $display("FAIL div1_pe_steady: got %0d low clks, want 0", pe_low);
        end
    endtask

    initial begin
        test_reset();
        rst_n = 1'b1;
        test_release("release");
        test_line();
        test_midreset();
        test_frame();
        test_div1();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
